fifo_access_arbiter: RTL and testbench
======================================

# fifo_access_arbiter

Sequencer and arbiter for the shared single-port FIFO RAM (64 x 8 by default) between one producer (switch/button write path) and one consumer (VGA display read path). Owns the write pointer, read pointer and occupancy count. Grants at most one RAM access per cycle and produces full/empty status. Drives the RAM address, write-enable and write-data directly, and flags read data as valid one cycle after a read access.

## Interface
- DEPTH_LOG2, 6, log2 of RAM depth; depth = 2**DEPTH_LOG2.
- DATA_W, 8, data width.

- clock  in  1  clock; all state updates on its rising edge.
- reset  in  1  reset, asynchronous, active-low.
- flush  in  1  synchronous clear of pointers, count and FSM; overrides everything.
- wr_req  in  1  producer request; held high until wr_gnt is seen.
- wr_data  in  DATA_W  producer data; must be stable while wr_req is high.
- rd_req  in  1  consumer request; held high until rd_gnt is seen.
- wr_gnt  out  1  one-cycle pulse; the write is performed this cycle.
- rd_gnt  out  1  one-cycle pulse; the read access is performed this cycle.
- rd_valid  out  1  high the cycle after rd_gnt; RAM q is valid for the consumer.
- ram_addr  out  DEPTH_LOG2  wr_ptr in WRITE, otherwise rd_ptr.
- ram_we  out  1  high only in WRITE.
- ram_wdata  out  DATA_W  wr_data registered at grant decision.
- full  out  1  count == 2**DEPTH_LOG2.
- empty  out  1  count == 0.
- count  out  DEPTH_LOG2+1  current occupancy.
- wr_blocked  out  1  registered; high for each cycle wr_req is high while full.

## Operation
- FSM states: IDLE, WRITE, READ. WRITE and READ each last exactly one cycle.
- Eligibility: wr_ok = wr_req && !full; rd_ok = rd_req && !empty. Both use the count held in the current cycle.
- IDLE:
  - only wr_ok -> WRITE; only rd_ok -> READ; neither -> IDLE.
  - both -> the side not served last, tracked by the last_wr flag (reset 0, so write wins the first tie).
- WRITE:
  - ram_we=1, ram_addr=wr_ptr, wr_gnt=1.
  - On exit: wr_ptr+1 (mod depth), count+1, last_wr=1.
  - Next state: READ if rd_req, else IDLE. After a write the FIFO is never empty, so no empty check is needed.
  - The same requester is never granted on consecutive cycles; the requester drops req after gnt.
- READ:
  - ram_addr=rd_ptr, rd_gnt=1.
  - On exit: rd_ptr+1 (mod depth), count-1, last_wr=0.
  - Next state: WRITE if wr_req, else IDLE. After a read the FIFO is never full.
- Pointers wrap from 2**DEPTH_LOG2-1 to 0. count is DEPTH_LOG2+1 bits wide, so it can hold the value 64 and full is unambiguous.
- ram_wdata is loaded from wr_data on the transition into WRITE.
- flush: next cycle pointers=0, count=0, state=IDLE, last_wr=0, rd_valid=0. Any access under way in that same cycle still drives ram_we/gnt, but its pointer/count update is discarded.
- Reset values:
  - state=IDLE; wr_ptr=rd_ptr=0; count=0; last_wr=0.
  - wr_gnt=rd_gnt=rd_valid=ram_we=wr_blocked=0; ram_addr=0; ram_wdata=0.
  - empty=1; full=0.
- Reset asserted mid-access aborts the access immediately; there is no pointer or count update.

## Timing
- Request to grant: 1 cycle minimum. Request seen high in cycle N in IDLE -> gnt in cycle N+1.
- Read data: rd_gnt in cycle M -> rd_valid (and RAM q) in cycle M+1.
- Peak throughput: one access per cycle when the requests alternate W,R,W,R. A single requester gets one access every 2 cycles (IDLE, access).
- full, empty and count are registered and change the cycle after WRITE or READ.
- All outputs are registered or decoded from registered state; there are no combinational paths from the req inputs to any output.

## Test plan
- Reset, then a single write of 0xA5 -> wr_gnt and ram_we 1 cycle after wr_req with ram_addr=0 and ram_wdata=0xA5. Afterwards count=1, empty=0.
- Fill: 64 writes -> full=1, count=64. A 65th wr_req gets no gnt, wr_blocked=1, and wr_ptr stays 0 after wrap.
- Drain: 64 reads from full -> ram_addr 0..63, rd_valid 1 cycle after each rd_gnt, and finally empty=1. An extra rd_req gets no grant.
- Contention: wr_req and rd_req held together with count=10 -> grants alternate W,R,W,R starting with W. count returns to 10 after each pair.
- Wrap: write 70 and read 70 interleaved -> both pointers wrap 63->0 and the data read matches the data written in order.
- flush in the middle of a WRITE with count=5 -> the next cycle shows count=0, empty=1, state IDLE. Async reset during a READ gives all reset values immediately.

Source files
------------

// File: rtl/fifo_access_arbiter_if.sv
// rtl/fifo_access_arbiter_if.sv - producer/consumer request and FIFO RAM bus for the access arbiter
interface fifo_access_arbiter_if #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 8
);
  logic                  flush;
  logic                  wr_req;
  logic [DATA_W-1:0]     wr_data;
  logic                  rd_req;
  logic                  wr_gnt;
  logic                  rd_gnt;
  logic                  rd_valid;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_W-1:0]     ram_wdata;
  logic                  full;
  logic                  empty;
  logic [DEPTH_LOG2:0]   count;
  logic                  wr_blocked;

  modport master (
    output flush, wr_req, wr_data, rd_req,
    input  wr_gnt, rd_gnt, rd_valid, ram_addr, ram_we, ram_wdata,
           full, empty, count, wr_blocked
  );

  modport slave (
    input  flush, wr_req, wr_data, rd_req,
    output wr_gnt, rd_gnt, rd_valid, ram_addr, ram_we, ram_wdata,
           full, empty, count, wr_blocked
  );
endinterface

// File: rtl/fifo_access_arbiter.sv
// rtl/fifo_access_arbiter.sv - single-port FIFO RAM sequencer arbitrating one writer and one reader
module fifo_access_arbiter #(
  parameter int DEPTH_LOG2 = 6,
  parameter int DATA_W     = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  fifo_access_arbiter_if.slave  bus
);
  localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2+1)'(1 << DEPTH_LOG2);

  typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, READ = 2'd2} state_t;

  state_t                r_state;
  state_t                w_next;
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_last_wr;
  logic                  r_rd_valid;
  logic                  r_wr_blocked;
  logic [DATA_W-1:0]     r_wdata;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_wr_ok;
  logic                  w_rd_ok;
  logic                  w_wr_gnt;
  logic                  w_rd_gnt;
  logic                  w_ram_we;
  logic [DEPTH_LOG2-1:0] w_ram_addr;

  assign w_full  = (r_count == FULL_CNT);
  assign w_empty = (r_count == '0);
  assign w_wr_ok = bus.wr_req && !w_full;
  assign w_rd_ok = bus.rd_req && !w_empty;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // After an access the other side is always eligible, so no status check is needed there.
  always_comb begin
    w_next = r_state;
    if (bus.flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_ok && w_rd_ok) w_next = r_last_wr ? READ : WRITE;
          else if (w_wr_ok)       w_next = WRITE;
          else if (w_rd_ok)       w_next = READ;
          else                    w_next = IDLE;
        end
        WRITE:   w_next = bus.rd_req ? READ : IDLE;
        READ:    w_next = bus.wr_req ? WRITE : IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    w_wr_gnt   = 1'b0;
    w_rd_gnt   = 1'b0;
    w_ram_we   = 1'b0;
    w_ram_addr = r_rd_ptr;
    case (r_state)
      WRITE: begin
        w_wr_gnt   = 1'b1;
        w_ram_we   = 1'b1;
        w_ram_addr = r_wr_ptr;
      end
      READ:    w_rd_gnt = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_last_wr    <= 1'b0;
      r_rd_valid   <= 1'b0;
      r_wr_blocked <= 1'b0;
      r_wdata      <= '0;
    end else begin
      r_wr_blocked <= bus.wr_req && w_full;
      if (r_state != WRITE && w_next == WRITE) r_wdata <= bus.wr_data;
      // A flush discards the bookkeeping of an access that is still driving the RAM.
      if (bus.flush) begin
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
        r_last_wr  <= 1'b0;
        r_rd_valid <= 1'b0;
      end else begin
        r_rd_valid <= (r_state == READ);
        case (r_state)
          WRITE: begin
            r_wr_ptr  <= r_wr_ptr + 1'b1;
            r_count   <= r_count + 1'b1;
            r_last_wr <= 1'b1;
          end
          READ: begin
            r_rd_ptr  <= r_rd_ptr + 1'b1;
            r_count   <= r_count - 1'b1;
            r_last_wr <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_gnt     = w_wr_gnt;
  assign bus.rd_gnt     = w_rd_gnt;
  assign bus.rd_valid   = r_rd_valid;
  assign bus.ram_addr   = w_ram_addr;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_wdata  = r_wdata;
  assign bus.full       = w_full;
  assign bus.empty      = w_empty;
  assign bus.count      = r_count;
  assign bus.wr_blocked = r_wr_blocked;
endmodule

// File: tb/tb_fifo_access_arbiter.sv
// tb/tb_fifo_access_arbiter.sv - directed bench for fifo_access_arbiter with a RAM model and data scoreboard
module tb_fifo_access_arbiter;
  logic clock;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   exp_wp = 0;
  int   exp_rp = 0;
  int   lat;
  logic [7:0] sb[$];
  logic [7:0] mem [64];
  logic [7:0] ram_q;

  fifo_access_arbiter_if bus ();

  fifo_access_arbiter dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM with registered read data, as the consumer sees it.
  always @(posedge clock) begin
    if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    ram_q <= mem[bus.ram_addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset === 1'b1 && bus.rd_valid === 1'b1) begin
      if (sb.size() == 0) check("rdata_underflow", 32'd0, 32'd1);
      else                check("rdata", ram_q, sb.pop_front());
    end
  end

  task automatic do_write(input logic [7:0] d, output int l);
    bus.wr_req  = 1'b1;
    bus.wr_data = d;
    l = 0;
    while (bus.wr_gnt !== 1'b1 && l < 8) begin
      @(negedge clock);
      l++;
    end
    check("wr_gnt_seen", bus.wr_gnt, 1);
    check("wr_we", bus.ram_we, 1);
    check("wr_addr", bus.ram_addr, exp_wp);
    check("wr_wdata", bus.ram_wdata, d);
    if (bus.wr_gnt === 1'b1) begin
      sb.push_back(d);
      exp_wp = (exp_wp + 1) % 64;
    end
    bus.wr_req = 1'b0;
    @(negedge clock);
  endtask

  task automatic do_read();
    int l = 0;
    bus.rd_req = 1'b1;
    while (bus.rd_gnt !== 1'b1 && l < 8) begin
      @(negedge clock);
      l++;
    end
    check("rd_gnt_seen", bus.rd_gnt, 1);
    check("rd_addr", bus.ram_addr, exp_rp);
    check("rd_no_we", bus.ram_we, 0);
    if (bus.rd_gnt === 1'b1) exp_rp = (exp_rp + 1) % 64;
    bus.rd_req = 1'b0;
    @(negedge clock);
    check("rd_valid", bus.rd_valid, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_wr_gnt"}, bus.wr_gnt, 0);
    check({tag, "_rd_gnt"}, bus.rd_gnt, 0);
    check({tag, "_rd_valid"}, bus.rd_valid, 0);
    check({tag, "_ram_we"}, bus.ram_we, 0);
    check({tag, "_ram_addr"}, bus.ram_addr, 0);
    check({tag, "_ram_wdata"}, bus.ram_wdata, 0);
    check({tag, "_wr_blocked"}, bus.wr_blocked, 0);
    check({tag, "_count"}, bus.count, 0);
    check({tag, "_empty"}, bus.empty, 1);
    check({tag, "_full"}, bus.full, 0);
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b0;
    bus.flush   = 1'b0;
    bus.wr_req  = 1'b0;
    bus.rd_req  = 1'b0;
    bus.wr_data = 8'h00;
    @(negedge clock);
    @(negedge clock);
    check_reset_values("reset");
    reset = 1'b1;
    @(negedge clock);

    do_write(8'hA5, lat);
    check("first_lat", lat, 1);
    check("one_count", bus.count, 1);
    check("one_empty", bus.empty, 0);

    for (int i = 1; i < 64; i++) do_write(8'(i), lat);
    check("fill_count", bus.count, 64);
    check("fill_full", bus.full, 1);
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'hEE;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("blocked_no_gnt", bus.wr_gnt, 0);
      check("blocked_flag", bus.wr_blocked, 1);
    end
    bus.wr_req = 1'b0;
    @(negedge clock);
    check("blocked_clear", bus.wr_blocked, 0);
    check("blocked_count", bus.count, 64);

    for (int i = 0; i < 64; i++) do_read();
    check("drain_empty", bus.empty, 1);
    check("drain_count", bus.count, 0);
    bus.rd_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("empty_no_gnt", bus.rd_gnt, 0);
    end
    bus.rd_req = 1'b0;
    @(negedge clock);

    for (int i = 0; i < 11; i++) do_write(8'h80 + 8'(i), lat);
    do_read();
    check("cont_start_count", bus.count, 10);
    bus.wr_data = 8'hC0;
    bus.wr_req  = 1'b1;
    bus.rd_req  = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      check("cont_wr_gnt", bus.wr_gnt, (k % 2 == 0) ? 1 : 0);
      check("cont_rd_gnt", bus.rd_gnt, (k % 2 == 1) ? 1 : 0);
      check("cont_count", bus.count, (k % 2 == 0) ? 10 : 11);
      check("cont_addr", bus.ram_addr, (k % 2 == 0) ? exp_wp : exp_rp);
      if (k % 2 == 0) begin
        check("cont_wdata", bus.ram_wdata, bus.wr_data);
        sb.push_back(bus.wr_data);
        exp_wp = (exp_wp + 1) % 64;
        bus.wr_data = bus.wr_data + 8'd1;
      end else begin
        exp_rp = (exp_rp + 1) % 64;
      end
    end
    bus.wr_req = 1'b0;
    bus.rd_req = 1'b0;
    @(negedge clock);
    check("cont_end_count", bus.count, 10);
    check("cont_end_idle", bus.wr_gnt, 0);

    for (int i = 0; i < 70; i++) begin
      do_write(8'(i) ^ 8'h5A, lat);
      do_read();
    end
    check("wrap_count", bus.count, 10);

    for (int i = 0; i < 5; i++) do_read();
    check("pre_flush_count", bus.count, 5);
    bus.wr_req  = 1'b1;
    bus.wr_data = 8'h77;
    lat = 0;
    while (bus.wr_gnt !== 1'b1 && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    check("flush_wr_we", bus.ram_we, 1);
    bus.flush  = 1'b1;
    bus.wr_req = 1'b0;
    @(negedge clock);
    bus.flush = 1'b0;
    sb.delete();
    exp_wp = 0;
    exp_rp = 0;
    check("flush_count", bus.count, 0);
    check("flush_empty", bus.empty, 1);
    check("flush_wr_gnt", bus.wr_gnt, 0);
    check("flush_rd_gnt", bus.rd_gnt, 0);
    check("flush_addr", bus.ram_addr, 0);
    check("flush_rd_valid", bus.rd_valid, 0);
    do_write(8'h11, lat);
    check("post_flush_lat", lat, 1);
    do_read();

    do_write(8'h21, lat);
    do_write(8'h22, lat);
    bus.rd_req = 1'b1;
    lat = 0;
    while (bus.rd_gnt !== 1'b1 && lat < 8) begin
      @(negedge clock);
      lat++;
    end
    check("arst_rd_gnt_before", bus.rd_gnt, 1);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("arst");
    @(negedge clock);
    bus.rd_req = 1'b0;
    sb.delete();
    exp_wp = 0;
    exp_rp = 0;
    reset = 1'b1;
    @(negedge clock);
    check("arst_after_count", bus.count, 0);
    do_write(8'h33, lat);
    do_read();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
